// File: rtl/single_cycle_core.sv
// single_cycle_core: RV32I-subset core that fetches, decodes, executes and commits one instruction per clock.
// Optional macro SCC_FULL_BRANCH_EN adds blt/bge/bltu/bgeu; without it those encodings execute as NOP.
`timescale 1ns/1ps

module scc_register_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] regs [0:31];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];
endmodule

module single_cycle_core (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr_data,
  output logic [31:0] data_addr,
  output logic [31:0] data_wd,
  output logic        data_write_enable,
  input  logic [31:0] data_data
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA
  } alu_op_e;
  typedef enum logic [1:0] {A_RS1, A_PC, A_ZERO} a_sel_e;
  typedef enum logic [1:0] {WB_ALU, WB_MEM, WB_LINK} wb_sel_e;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;

  typedef struct packed {
    logic     reg_we;
    wb_sel_e  wb;
    a_sel_e   asel;
    logic     bsel_imm;
    imm_sel_e imm_sel;
    alu_op_e  op;
    logic     store;
    logic     branch;
    logic     jal;
    logic     jalr;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    reg_we: 1'b0, wb: WB_ALU, asel: A_RS1, bsel_imm: 1'b0, imm_sel: IMM_I,
    op: ALU_ADD, store: 1'b0, branch: 1'b0, jal: 1'b0, jalr: 1'b0
  };

  logic [31:0] pc, pc_next, pc_plus4, pc_target;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val, imm, alu_a, alu_b, alu_y, wb_data;
  logic        br_taken, rf_we;
  ctrl_t       ctrl;
  alu_op_e     base_op;

  assign opcode = instr_data[6:0];
  assign funct3 = instr_data[14:12];
  assign funct7 = instr_data[31:25];

  // funct3 -> ALU op for the register/immediate arithmetic groups
  always_comb begin
    base_op = ALU_ADD;
    case (funct3)
      3'b000: base_op = ALU_ADD;
      3'b001: base_op = ALU_SLL;
      3'b010: base_op = ALU_SLT;
      3'b011: base_op = ALU_SLTU;
      3'b100: base_op = ALU_XOR;
      3'b101: base_op = ALU_SRL;
      3'b110: base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  end

  // Unrecognized encodings leave ctrl at CTRL_NOP: PC+4, no writes
  always_comb begin
    ctrl = CTRL_NOP;
    case (opcode)
      OP_LUI: begin
        ctrl.reg_we   = 1'b1;
        ctrl.asel     = A_ZERO;
        ctrl.bsel_imm = 1'b1;
        ctrl.imm_sel  = IMM_U;
      end
      OP_AUIPC: begin
        ctrl.reg_we   = 1'b1;
        ctrl.asel     = A_PC;
        ctrl.bsel_imm = 1'b1;
        ctrl.imm_sel  = IMM_U;
      end
      OP_JAL: begin
        ctrl.reg_we  = 1'b1;
        ctrl.wb      = WB_LINK;
        ctrl.imm_sel = IMM_J;
        ctrl.jal     = 1'b1;
      end
      OP_JALR: begin
        if (funct3 == 3'b000) begin
          ctrl.reg_we   = 1'b1;
          ctrl.wb       = WB_LINK;
          ctrl.bsel_imm = 1'b1;
          ctrl.jalr     = 1'b1;
        end
      end
      OP_BRANCH: begin
        ctrl.imm_sel = IMM_B;
        ctrl.branch  = 1'b1;
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          ctrl.reg_we   = 1'b1;
          ctrl.wb       = WB_MEM;
          ctrl.bsel_imm = 1'b1;
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b010) begin
          ctrl.store    = 1'b1;
          ctrl.bsel_imm = 1'b1;
          ctrl.imm_sel  = IMM_S;
        end
      end
      OP_IMM: begin
        ctrl.bsel_imm = 1'b1;
        ctrl.op       = base_op;
        case (funct3)
          3'b001: ctrl.reg_we = (funct7 == 7'b0000000);
          3'b101: begin
            ctrl.reg_we = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            if (funct7 == 7'b0100000) ctrl.op = ALU_SRA;
          end
          default: ctrl.reg_we = 1'b1;
        endcase
      end
      OP_REG: begin
        ctrl.op = base_op;
        if (funct7 == 7'b0000000) begin
          ctrl.reg_we = 1'b1;
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000) begin
            ctrl.reg_we = 1'b1;
            ctrl.op     = ALU_SUB;
          end else if (funct3 == 3'b101) begin
            ctrl.reg_we = 1'b1;
            ctrl.op     = ALU_SRA;
          end
        end
      end
      default: ctrl = CTRL_NOP;
    endcase
  end

  always_comb begin
    imm = '0;
    case (ctrl.imm_sel)
      IMM_I:   imm = {{20{instr_data[31]}}, instr_data[31:20]};
      IMM_S:   imm = {{20{instr_data[31]}}, instr_data[31:25], instr_data[11:7]};
      IMM_B:   imm = {{19{instr_data[31]}}, instr_data[31], instr_data[7],
                      instr_data[30:25], instr_data[11:8], 1'b0};
      IMM_U:   imm = {instr_data[31:12], 12'b0};
      IMM_J:   imm = {{11{instr_data[31]}}, instr_data[31], instr_data[19:12],
                      instr_data[20], instr_data[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  assign rf_we = ctrl.reg_we & ~rst;

  scc_register_file register_file (
    .clk (clk),
    .rst (rst),
    .we  (rf_we),
    .ra1 (instr_data[19:15]),
    .ra2 (instr_data[24:20]),
    .wa  (instr_data[11:7]),
    .wd  (wb_data),
    .rd1 (rs1_val),
    .rd2 (rs2_val)
  );

  always_comb begin
    alu_a = rs1_val;
    case (ctrl.asel)
      A_PC:    alu_a = pc;
      A_ZERO:  alu_a = '0;
      default: alu_a = rs1_val;
    endcase
  end

  assign alu_b = ctrl.bsel_imm ? imm : rs2_val;

  always_comb begin
    alu_y = alu_a + alu_b;
    case (ctrl.op)
      ALU_SUB:  alu_y = alu_a - alu_b;
      ALU_AND:  alu_y = alu_a & alu_b;
      ALU_OR:   alu_y = alu_a | alu_b;
      ALU_XOR:  alu_y = alu_a ^ alu_b;
      ALU_SLT:  alu_y = {31'b0, $signed(alu_a) < $signed(alu_b)};
      ALU_SLTU: alu_y = {31'b0, alu_a < alu_b};
      ALU_SLL:  alu_y = alu_a << alu_b[4:0];
      ALU_SRL:  alu_y = alu_a >> alu_b[4:0];
      ALU_SRA:  alu_y = $signed(alu_a) >>> alu_b[4:0];
      default:  alu_y = alu_a + alu_b;
    endcase
  end

  // Branch unit: funct3 010/011 and (unless enabled) the ordered compares are never taken
  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'b000: br_taken = (rs1_val == rs2_val);
      3'b001: br_taken = (rs1_val != rs2_val);
`ifdef SCC_FULL_BRANCH_EN
      3'b100: br_taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101: br_taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110: br_taken = (rs1_val <  rs2_val);
      3'b111: br_taken = (rs1_val >= rs2_val);
`else
      3'b100, 3'b101, 3'b110, 3'b111: br_taken = 1'b0;
`endif
      default: br_taken = 1'b0;
    endcase
  end

  assign pc_plus4  = pc + 32'd4;
  assign pc_target = pc + imm;

  always_comb begin
    pc_next = pc_plus4;
    if (ctrl.jalr)
      pc_next = {alu_y[31:1], 1'b0};
    else if (ctrl.jal || (ctrl.branch && br_taken))
      pc_next = pc_target;
  end

  always_comb begin
    wb_data = alu_y;
    case (ctrl.wb)
      WB_MEM:  wb_data = data_data;
      WB_LINK: wb_data = pc_plus4;
      default: wb_data = alu_y;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= '0;
    else     pc <= pc_next;
  end

  assign instr_addr        = pc;
  assign data_addr         = alu_y;
  assign data_wd           = rs2_val;
  assign data_write_enable = ctrl.store & ~rst;
endmodule

// File: tb/tb_single_cycle_core.sv
// Directed bench for single_cycle_core: ROM/RAM models, per-step expectations queued and drained after each commit.
`timescale 1ns/1ps

module tb_single_cycle_core;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_addr, instr_data, data_addr, data_wd, data_data;
  logic        data_write_enable;

  logic [31:0] rom [0:63];
  logic [31:0] ram [0:63];

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          kind;  // 0 reg, 1 pc, 2 data_addr, 3 data_wd, 4 write enable, 5 ram word
    int          idx;
    logic [31:0] val;
  } exp_t;
  exp_t sbq[$];

  localparam logic [31:0] NOP = 32'h00000013;

  single_cycle_core dut (
    .clk               (clk),
    .rst               (rst),
    .instr_addr        (instr_addr),
    .instr_data        (instr_data),
    .data_addr         (data_addr),
    .data_wd           (data_wd),
    .data_write_enable (data_write_enable),
    .data_data         (data_data)
  );

  always #5 clk = ~clk;

  assign instr_data = rom[instr_addr[7:2]];
  assign data_data  = ram[data_addr[7:2]];
  always @(posedge clk) if (data_write_enable) ram[data_addr[7:2]] <= data_wd;

  function automatic logic [31:0] enc_i(input logic [31:0] im, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {im[11:0], rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] im, input logic [4:0] rs2, input logic [4:0] rs1);
    return {im[11:5], rs2, rs1, 3'b010, im[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] im, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3);
    return {im[12], im[10:5], rs2, rs1, f3, im[4:1], im[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] im, input logic [4:0] rd);
    return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] im, input logic [4:0] rd, input logic [6:0] op);
    return {im, rd, op};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input int kind, input int idx, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.kind = kind; e.idx = idx; e.val = v;
    sbq.push_back(e);
  endtask
  task automatic exp_reg(input int i, input logic [31:0] v);
    push($sformatf("x%0d@pc%h", i, instr_addr), 0, i, v);
  endtask
  task automatic exp_pc(input logic [31:0] v);
    push($sformatf("pc_after_%h", instr_addr), 1, 0, v);
  endtask

  task automatic drain();
    logic [31:0] obs;
    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      case (e.kind)
        0:       obs = dut.register_file.regs[e.idx];
        1:       obs = instr_addr;
        2:       obs = data_addr;
        3:       obs = data_wd;
        4:       obs = {31'b0, data_write_enable};
        default: obs = ram[e.idx];
      endcase
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    drain();
  endtask

  task automatic reset_and_load_start();
    rst = 1'b1;
    for (int i = 0; i < 64; i++) begin
      rom[i] = NOP;
      ram[i] = '0;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // ---------------- Program A: ALU sequence ----------------
    reset_and_load_start();
    rom[0] = enc_i(32'd5, 5'd0, 3'b000, 5'd1, 7'b0010011);
    rom[1] = enc_i(32'hFFD, 5'd0, 3'b000, 5'd2, 7'b0010011);
    rom[2] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
    rom[3] = enc_r(7'h20, 5'd1, 5'd2, 3'b000, 5'd4);
    rom[4] = enc_r(7'h00, 5'd1, 5'd2, 3'b010, 5'd5);
    rom[5] = enc_r(7'h00, 5'd1, 5'd2, 3'b011, 5'd6);
    rom[6] = enc_i(32'h401, 5'd2, 3'b101, 5'd7, 7'b0010011);
    rom[7] = enc_i(32'd28, 5'd2, 3'b101, 5'd8, 7'b0010011);
    rom[8] = enc_r(7'h00, 5'd1, 5'd1, 3'b001, 5'd9);
    #1;
    push("reset_pc", 1, 0, 32'h0);
    push("reset_we", 4, 0, 32'h0);
    for (int i = 0; i < 32; i++) push($sformatf("reset_x%0d", i), 0, i, 32'h0);
    drain();
    release_reset();
    exp_pc(32'h04); exp_reg(1, 32'd5);                      step();
    exp_pc(32'h08); exp_reg(2, 32'hFFFFFFFD);               step();
    exp_reg(3, 32'd2);                                      step();
    exp_reg(4, 32'hFFFFFFF8);                               step();
    exp_reg(5, 32'd1);                                      step();
    exp_pc(32'h18); exp_reg(6, 32'd0);                      step();
    exp_reg(7, 32'hFFFFFFFE);                               step();
    exp_reg(8, 32'h0000000F);                               step();
    exp_pc(32'h24); exp_reg(9, 32'h000000A0);               step();

    // ---------------- Program B: memory, x0, control flow, mid-cycle reset ----------------
    reset_and_load_start();
    rom[0]  = enc_i(32'h10, 5'd0, 3'b000, 5'd1, 7'b0010011);
    rom[1]  = enc_s(32'd4, 5'd1, 5'd1);
    rom[2]  = enc_i(32'd4, 5'd1, 3'b010, 5'd7, 7'b0000011);
    rom[3]  = enc_i(32'd7, 5'd0, 3'b000, 5'd0, 7'b0010011);
    rom[4]  = enc_b(32'd8, 5'd0, 5'd0, 3'b000);
    rom[5]  = enc_i(32'd1, 5'd0, 3'b000, 5'd10, 7'b0010011);
    rom[6]  = enc_b(32'd8, 5'd0, 5'd0, 3'b001);
    rom[7]  = enc_b(32'd16, 5'd7, 5'd1, 3'b001);
    rom[8]  = enc_j(32'hFFFFFFFC, 5'd1);
    rom[11] = enc_i(32'd1, 5'd1, 3'b000, 5'd1, 7'b0010011);
    rom[12] = enc_i(32'd0, 5'd1, 3'b000, 5'd2, 7'b1100111);
    release_reset();
    exp_pc(32'h04); exp_reg(1, 32'h10);                     step();
    push("sw_addr", 2, 0, 32'h14);
    push("sw_wd",   3, 0, 32'h10);
    push("sw_we",   4, 0, 32'h1);
    drain();
    // Asynchronous pulse in the middle of the store cycle: nothing may commit
    #2 rst = 1'b1;
    #1;
    push("midrst_pc", 1, 0, 32'h0);
    push("midrst_we", 4, 0, 32'h0);
    push("midrst_x1", 0, 1, 32'h0);
    drain();
    rst = 1'b0;
    exp_pc(32'h04); exp_reg(1, 32'h10);
    push("ram_untouched", 5, 5, 32'h0);                     step();
    exp_pc(32'h08); push("ram_store", 5, 5, 32'h10);
    push("we_one_cycle", 4, 0, 32'h0);
    push("lw_addr", 2, 0, 32'h14);                          step();
    exp_pc(32'h0C); exp_reg(7, 32'h10);                     step();
    exp_pc(32'h10); exp_reg(0, 32'h0);                      step();
    exp_pc(32'h18);                                         step();
    exp_pc(32'h1C); exp_reg(10, 32'h0);                     step();
    exp_pc(32'h20);                                         step();
    exp_pc(32'h1C); exp_reg(1, 32'h24);                     step();
    exp_pc(32'h2C);                                         step();
    exp_pc(32'h30); exp_reg(1, 32'h25);                     step();
    exp_pc(32'h24); exp_reg(2, 32'h34);                     step();

    // ---------------- Program C: upper immediates, illegal op, optional branches ----------------
    reset_and_load_start();
    rom[0]  = enc_u(20'h12345, 5'd8, 7'b0110111);
    rom[1]  = enc_i(32'd1, 5'd0, 3'b000, 5'd1, 7'b0010011);
    rom[2]  = enc_i(32'hFFF, 5'd0, 3'b000, 5'd2, 7'b0010011);
    rom[3]  = enc_r(7'h01, 5'd2, 5'd1, 3'b000, 5'd3);
    rom[4]  = enc_j(32'h20, 5'd0);
    rom[12] = enc_u(20'h00001, 5'd9, 7'b0010111);
    rom[13] = enc_b(32'd12, 5'd1, 5'd2, 3'b100);
    rom[16] = enc_b(32'd16, 5'd1, 5'd2, 3'b111);
    release_reset();
    exp_pc(32'h04); exp_reg(8, 32'h12345000);               step();
    exp_reg(1, 32'd1);                                      step();
    exp_reg(2, 32'hFFFFFFFF);                               step();
    exp_pc(32'h10); exp_reg(3, 32'h0);                      step();
    exp_pc(32'h30); exp_reg(0, 32'h0);                      step();
    exp_pc(32'h34); exp_reg(9, 32'h00001030);               step();
`ifdef SCC_FULL_BRANCH_EN
    exp_pc(32'h40);                                         step();
    exp_pc(32'h50);                                         step();
`else
    exp_pc(32'h38);                                         step();
    exp_pc(32'h3C);                                         step();
    exp_pc(32'h40);                                         step();
    exp_pc(32'h44);                                         step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
